hazard_aer_serializer: RTL and testbench
========================================

HAZARD_AER_SERIALIZER -- requirements
Module: hazard_aer_serializer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, declared first: clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 frame_valid  input  1  a grid frame is offered on vec1/vec2.
REQ-005 frame_ready  output  1  block can accept a frame this cycle.
REQ-006 vec1  input  16  grid cells 0-15 (bit n = cell n, row*8+col).
REQ-007 vec2  input  16  grid cells 16-31 (bit n = cell n+16).
REQ-008 aer_valid  output  1  spike event is presented on aer_addr.
REQ-009 aer_ready  input  1  downstream SNN core accepts the event.
REQ-010 aer_addr  output  5  cell index 0-31 of the presented spike.
REQ-011 aer_last  output  1  presented event is the final spike of the frame.
REQ-012 frame_done  output  1  one-cycle pulse, the frame is fully serialized.

Function
REQ-013 SHALL convert each accepted 32-cell occupancy frame into address-event spikes, one per set cell, ascending cell index.
REQ-014 States SHALL be IDLE, SCAN and DONE only.
REQ-015 IDLE: frame_ready=1; aer_valid=0; frame accepted on frame_valid&&frame_ready; mask <= {vec2,vec1}.
REQ-016 IDLE transition: accepted nonzero mask -> SCAN; accepted zero mask -> DONE; else stay.
REQ-017 SCAN: frame_ready=0, aer_valid=1, aer_addr=index of lowest set mask bit, aer_last=1 iff mask has exactly one bit set.
REQ-018 SCAN: on aer_valid&&aer_ready clear that bit; if aer_last then -> DONE, else stay in SCAN.
REQ-019 SCAN with aer_ready=0: aer_addr, aer_last, aer_valid SHALL hold stable until the handshake completes.
REQ-020 DONE: frame_done=1 for exactly one cycle, frame_ready=0, then -> IDLE.
REQ-021 Latency: frame accepted at edge N -> first aer_valid high after edge N; aer_ready held high -> one event per cycle.
REQ-022 Full frame (0xFFFF_FFFF) SHALL yield exactly 32 events, addresses 0..31, aer_last on address 31.
REQ-023 Empty frame SHALL yield zero events and still pulse frame_done one cycle after acceptance.
REQ-024 aer_valid, aer_addr, aer_last, frame_ready SHALL depend only on registered state (no combinational path from aer_ready or frame_valid).
REQ-025 frame_valid while frame_ready=0 SHALL be ignored; the upstream encoder holds its frame.
REQ-026 Minimum frame period = popcount + 2 cycles (accept, events, DONE).

Reset
REQ-027 rst SHALL force IDLE, mask=0, frame_ready=1, aer_valid=0, aer_addr=0, aer_last=0, frame_done=0 immediately, independent of clk.
REQ-028 Reset mid-SCAN SHALL discard all pending events; no frame_done is generated for the aborted frame.
REQ-029 First frame acceptance SHALL be possible on the first rising clk edge after rst deasserts.

Configuration
REQ-030 Macro AER_FRAME_ID_EN SHALL add output aer_frame_id (16 bits): index of the frame the current event belongs to.
REQ-031 With AER_FRAME_ID_EN: a counter, reset 0, increments on every accepted frame (empty included), wraps 0xFFFF->0x0000; aer_frame_id = counter value captured at acceptance, stable for all events of that frame.
REQ-032 Without AER_FRAME_ID_EN: port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 vec2=0x0000, vec1=0x0005, aer_ready=1 -> events addr 0 then 2, aer_last on 2, frame_done next cycle.
REQ-034 vec2=0x8000, vec1=0x0001, aer_ready low 3 cycles at first event -> addr 0 held stable 3 cycles, then 0, 31 with aer_last on 31.
REQ-035 vec1=vec2=0x0000 -> no aer_valid, frame_done pulses one cycle after acceptance, frame_ready=1 again the cycle after.
REQ-036 vec1=vec2=0xFFFF, aer_ready=1 -> 32 consecutive events 0..31, frame_ready low for 33 cycles after acceptance.
REQ-037 rst asserted after 3 of 32 events -> aer_valid drops immediately, no frame_done, next frame vec1=0x0010 -> single event addr 4.
REQ-038 AER_FRAME_ID_EN defined, 65537 empty frames then vec1=0x0002 -> event addr 1 with aer_frame_id=0x0001.

Source files
------------

// File: rtl/hazard_aer_serializer.sv
`default_nettype none
// ============================================================================
// Module   : hazard_aer_serializer
// Brief    : Serializes a 32-cell occupancy frame into ascending address-event
//            spikes with a valid/ready handshake and a frame_done pulse.
//            Define AER_FRAME_ID_EN to add the aer_frame_id output.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_aer_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [15:0] vec1,
    input  logic [15:0] vec2,
    output logic        aer_valid,
    input  logic        aer_ready,
    output logic [4:0]  aer_addr,
    output logic        aer_last,
`ifdef AER_FRAME_ID_EN
    output logic [15:0] aer_frame_id,
`endif
    output logic        frame_done
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_SCAN = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_mask;
    logic        r_frame_ready;
    logic        r_aer_valid;
    logic [4:0]  r_aer_addr;
    logic        r_aer_last;
    logic        r_frame_done;

    logic [31:0] w_frame;
    logic [31:0] w_mask_clr;
    logic [31:0] w_src;
    logic [4:0]  w_low_idx;
    logic        w_single;
    logic        w_accept;

    assign w_frame    = {vec2, vec1};
    assign w_mask_clr = r_mask & (r_mask - 32'd1);
    assign w_accept   = frame_valid && r_frame_ready;

    // Next presented event is looked up from whichever mask the upcoming cycle
    // will hold, so address/last can be registered one edge ahead.
    assign w_src    = (r_state == c_S_IDLE) ? w_frame : w_mask_clr;
    assign w_single = (w_src != 32'd0) && ((w_src & (w_src - 32'd1)) == 32'd0);

    always_comb begin
        w_low_idx = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (w_src[i]) begin
                w_low_idx = 5'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_S_IDLE;
            r_mask        <= 32'd0;
            r_frame_ready <= 1'b1;
            r_aer_valid   <= 1'b0;
            r_aer_addr    <= 5'd0;
            r_aer_last    <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_mask        <= w_frame;
                        r_frame_ready <= 1'b0;
                        if (w_frame != 32'd0) begin
                            r_state     <= c_S_SCAN;
                            r_aer_valid <= 1'b1;
                            r_aer_addr  <= w_low_idx;
                            r_aer_last  <= w_single;
                        end else begin
                            r_state      <= c_S_DONE;
                            r_frame_done <= 1'b1;
                        end
                    end
                end
                c_S_SCAN: begin
                    if (aer_ready) begin
                        r_mask <= w_mask_clr;
                        if (r_aer_last) begin
                            r_state      <= c_S_DONE;
                            r_aer_valid  <= 1'b0;
                            r_aer_last   <= 1'b0;
                            r_aer_addr   <= 5'd0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_aer_addr <= w_low_idx;
                            r_aer_last <= w_single;
                        end
                    end
                end
                c_S_DONE: begin
                    r_state       <= c_S_IDLE;
                    r_frame_done  <= 1'b0;
                    r_frame_ready <= 1'b1;
                end
                default: begin
                    r_state       <= c_S_IDLE;
                    r_mask        <= 32'd0;
                    r_frame_ready <= 1'b1;
                    r_aer_valid   <= 1'b0;
                    r_aer_last    <= 1'b0;
                    r_frame_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AER_FRAME_ID_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_frame_id;

    // Every accepted frame, empty ones included, consumes an index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
            r_frame_id  <= 16'd0;
        end else if (w_accept) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_frame_id  <= r_frame_cnt;
        end
    end

    assign aer_frame_id = r_frame_id;
`endif

    assign frame_ready = r_frame_ready;
    assign aer_valid   = r_aer_valid;
    assign aer_addr    = r_aer_addr;
    assign aer_last    = r_aer_last;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hazard_aer_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_aer_serializer
// Brief    : Self-checking bench: directed frame table, reset-abort sequence
//            and randomized frames against an event-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_aer_serializer;

    logic        clk;
    logic        rst;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] vec1;
    logic [15:0] vec2;
    logic        aer_valid;
    logic        aer_ready;
    logic [4:0]  aer_addr;
    logic        aer_last;
    logic        frame_done;
`ifdef AER_FRAME_ID_EN
    logic [15:0] aer_frame_id;
`endif

    int r_tests;
    int r_failed;
    int r_frames;

    hazard_aer_serializer u_dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .vec1        (vec1),
        .vec2        (vec2),
        .aer_valid   (aer_valid),
        .aer_ready   (aer_ready),
        .aer_addr    (aer_addr),
        .aer_last    (aer_last),
`ifdef AER_FRAME_ID_EN
        .aer_frame_id(aer_frame_id),
`endif
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] v1;
        logic [15:0] v2;
        int          stall_first;
        int          exp_events;
        int          exp_last_addr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        r_tests++;
        if (act !== exp) begin
            r_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the frame is the ordered list of its set cell indices; each
    // accepted handshake consumes the list head, then one DONE cycle follows.
    task automatic run_frame(input logic [15:0] v1, input logic [15:0] v2,
                             input int stall_first, input int rdy_pct,
                             output int n_ev, output int last_addr);
        int          exp_q[$];
        int          guard;
        int          stall;
        logic [31:0] m;
        m = {v2, v1};
        exp_q = {};
        for (int i = 0; i < 32; i++) if (m[i]) exp_q.push_back(i);
        n_ev = 0;
        last_addr = -1;
        stall = stall_first;
        guard = 0;
        check("idle_frame_ready", {31'd0, frame_ready}, 32'd1);
        check("idle_aer_valid", {31'd0, aer_valid}, 32'd0);
        frame_valid = 1'b1;
        vec1 = v1;
        vec2 = v2;
        aer_ready = 1'b0;
        @(posedge clk); #1;
        while (exp_q.size() > 0 && guard < 300) begin
            check("scan_valid", {31'd0, aer_valid}, 32'd1);
            check("scan_addr", {27'd0, aer_addr}, exp_q[0]);
            check("scan_last", {31'd0, aer_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
            check("scan_frame_ready", {31'd0, frame_ready}, 32'd0);
            check("scan_frame_done", {31'd0, frame_done}, 32'd0);
`ifdef AER_FRAME_ID_EN
            check("frame_id", {16'd0, aer_frame_id}, 32'(r_frames[15:0]));
`endif
            if (stall > 0) begin
                aer_ready = 1'b0;
                stall--;
            end else begin
                aer_ready = ($urandom_range(99) < rdy_pct);
            end
            // Busy-time offers must be ignored.
            frame_valid = $urandom_range(1);
            vec1 = 16'($urandom);
            vec2 = 16'($urandom);
            @(posedge clk); #1;
            if (aer_ready) begin
                last_addr = exp_q.pop_front();
                n_ev++;
            end
            guard++;
        end
        if (guard >= 300) begin
            r_tests++;
            r_failed++;
            $display("FAIL scan_timeout: got %0d events pending expected 0", exp_q.size());
        end
        check("done_pulse", {31'd0, frame_done}, 32'd1);
        check("done_aer_valid", {31'd0, aer_valid}, 32'd0);
        check("done_frame_ready", {31'd0, frame_ready}, 32'd0);
        frame_valid = 1'b0;
        aer_ready = 1'b0;
        @(posedge clk); #1;
        check("post_done_pulse", {31'd0, frame_done}, 32'd0);
        check("post_frame_ready", {31'd0, frame_ready}, 32'd1);
        r_frames++;
    endtask

    initial begin
        vec_t tbl[5];
        int   n_ev;
        int   last_a;
        int   cnt;
        logic [31:0] m;

        r_tests = 0;
        r_failed = 0;
        r_frames = 0;
        tbl[0] = '{16'h0005, 16'h0000, 0, 2, 2};
        tbl[1] = '{16'h0001, 16'h8000, 3, 2, 31};
        tbl[2] = '{16'h0000, 16'h0000, 0, 0, -1};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 0, 32, 31};
        tbl[4] = '{16'h8421, 16'h0000, 1, 4, 15};

        rst = 1'b1;
        frame_valid = 1'b0;
        aer_ready = 1'b0;
        vec1 = 16'd0;
        vec2 = 16'd0;
        #1;
        check("rst_frame_ready", {31'd0, frame_ready}, 32'd1);
        check("rst_aer_valid", {31'd0, aer_valid}, 32'd0);
        check("rst_aer_addr", {27'd0, aer_addr}, 32'd0);
        check("rst_aer_last", {31'd0, aer_last}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            run_frame(tbl[t].v1, tbl[t].v2, tbl[t].stall_first, 100, n_ev, last_a);
            check($sformatf("tbl%0d_events", t), n_ev, tbl[t].exp_events);
            check($sformatf("tbl%0d_last_addr", t), last_a, tbl[t].exp_last_addr);
        end

        // Abort a full frame after three events.
        frame_valid = 1'b1;
        vec1 = 16'hFFFF;
        vec2 = 16'hFFFF;
        aer_ready = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort_addr", {27'd0, aer_addr}, k);
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        check("abort_aer_valid", {31'd0, aer_valid}, 32'd0);
        check("abort_frame_ready", {31'd0, frame_ready}, 32'd1);
        check("abort_aer_addr", {27'd0, aer_addr}, 32'd0);
        check("abort_frame_done", {31'd0, frame_done}, 32'd0);
        aer_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        r_frames = 0;
        for (int k = 0; k < 3; k++) begin
            check("abort_no_done", {31'd0, frame_done}, 32'd0);
            check("abort_no_valid", {31'd0, aer_valid}, 32'd0);
            @(posedge clk); #1;
        end
        run_frame(16'h0010, 16'h0000, 0, 100, n_ev, last_a);
        check("after_abort_events", n_ev, 1);
        check("after_abort_addr", last_a, 4);

        for (int r = 0; r < 40; r++) begin
            m = $urandom;
            if (r % 3 == 0) m = m & $urandom & $urandom;
            if (r == 7) m = 32'h8000_0000;
            cnt = 0;
            last_a = -1;
            for (int i = 0; i < 32; i++) if (m[i]) begin cnt++; last_a = i; end
            begin
                int exp_last;
                exp_last = last_a;
                run_frame(m[15:0], m[31:16], $urandom_range(2), 60, n_ev, last_a);
                check("rnd_events", n_ev, cnt);
                check("rnd_last_addr", last_a, exp_last);
            end
        end

        $display("[TB] %0d tests run, %0d failed", r_tests, r_failed);
        $finish;
    end

endmodule
`default_nettype wire
